// File: rtl/lvds_align_pkg.sv
// Shared types and counter-width helpers for the LVDS word aligner.
// Optional feature macro used by the design: LVDS_ALIGN_SLIPCNT_EN.
package lvds_align_pkg;

    typedef enum logic [2:0] {
        LaneIdle,
        LaneCheck,
        LaneSlip,
        LaneSettle,
        LaneLocked,
        LaneFail
    } lane_state_e;

    // Width of a counter that must hold values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/lvds_align_lane.sv
// One lane of the LVDS word aligner: train/slip/settle FSM with saturating counters.
// LVDS_ALIGN_SLIPCNT_EN exposes the lane's slip counter.
module lvds_align_lane
    import lvds_align_pkg::*;
#(
    parameter int unsigned              DESER_FACTOR  = 8,
    parameter logic [DESER_FACTOR-1:0]  TRAIN_PATTERN = 8'hF0,
    parameter int unsigned              MATCH_COUNT   = 16,
    parameter int unsigned              SLIP_SETTLE   = 4,
    parameter int unsigned              MAX_SLIPS     = 2 * DESER_FACTOR
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              pll_locked,
    input  logic                              start,
    input  logic [DESER_FACTOR-1:0]           rx_word,
    output logic                              bitslip,
    output logic                              aligned,
    output logic                              failed,
    output logic                              busy
`ifdef LVDS_ALIGN_SLIPCNT_EN
    ,
    output logic [cnt_width(MAX_SLIPS)-1:0]   slip_cnt
`endif
);

    localparam int unsigned MW = cnt_width(MATCH_COUNT);
    localparam int unsigned SW = cnt_width(MAX_SLIPS);
    localparam int unsigned TW = cnt_width(SLIP_SETTLE);

    localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_COUNT - 1);
    localparam logic [MW-1:0] MATCH_MAX   = MW'(MATCH_COUNT);
    localparam logic [SW-1:0] SLIP_MAX    = SW'(MAX_SLIPS);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SLIP_SETTLE - 1);

    lane_state_e   state_q, state_d;
    logic [MW-1:0] match_q, match_d;
    logic [SW-1:0] slip_q,  slip_d;
    logic [TW-1:0] settle_q, settle_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= LaneIdle;
            match_q  <= '0;
            slip_q   <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            match_q  <= match_d;
            slip_q   <= slip_d;
            settle_q <= settle_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        slip_d   = slip_q;
        settle_d = settle_q;
        // PLL loss dominates everything, then a qualified restart.
        if (!pll_locked) begin
            state_d  = LaneIdle;
            match_d  = '0;
            slip_d   = '0;
            settle_d = '0;
        end else if (start) begin
            state_d  = LaneCheck;
            match_d  = '0;
            slip_d   = '0;
            settle_d = '0;
        end else begin
            unique case (state_q)
                LaneCheck: begin
                    if (rx_word == TRAIN_PATTERN) begin
                        if (match_q != MATCH_MAX) match_d = match_q + 1'b1;
                        if (match_q == MATCH_LAST) state_d = LaneLocked;
                    end else begin
                        match_d = '0;
                        state_d = (slip_q < SLIP_MAX) ? LaneSlip : LaneFail;
                    end
                end
                LaneSlip: begin
                    if (slip_q != SLIP_MAX) slip_d = slip_q + 1'b1;
                    settle_d = '0;
                    state_d  = LaneSettle;
                end
                LaneSettle: begin
                    if (settle_q == SETTLE_LAST) begin
                        settle_d = '0;
                        state_d  = LaneCheck;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bitslip = (state_q == LaneSlip);
    assign aligned = (state_q == LaneLocked);
    assign failed  = (state_q == LaneFail);
    assign busy    = (state_q == LaneCheck) || (state_q == LaneSlip) || (state_q == LaneSettle);

`ifdef LVDS_ALIGN_SLIPCNT_EN
    assign slip_cnt = slip_q;
`endif

endmodule

// File: rtl/lvds_word_aligner.sv
// Multi-lane LVDS word aligner: start/lock qualification, lane array, aggregate status.
// LVDS_ALIGN_SLIPCNT_EN adds the per-lane slip_count output.
module lvds_word_aligner
    import lvds_align_pkg::*;
#(
    parameter int unsigned              CHANNELS      = 4,
    parameter int unsigned              DESER_FACTOR  = 8,
    parameter logic [DESER_FACTOR-1:0]  TRAIN_PATTERN = 8'hF0,
    parameter int unsigned              MATCH_COUNT   = 16,
    parameter int unsigned              SLIP_SETTLE   = 4,
    parameter int unsigned              MAX_SLIPS     = 2 * DESER_FACTOR
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               pll_locked,
    input  logic                               align_start,
    input  logic [CHANNELS*DESER_FACTOR-1:0]   rx_data,
    output logic [CHANNELS-1:0]                rx_bitslip,
    output logic [CHANNELS-1:0]                ch_aligned,
    output logic [CHANNELS-1:0]                ch_fail,
    output logic                               all_aligned,
    output logic                               align_busy
`ifdef LVDS_ALIGN_SLIPCNT_EN
    ,
    output logic [CHANNELS*cnt_width(MAX_SLIPS)-1:0] slip_count
`endif
);

    localparam int unsigned SCW = cnt_width(MAX_SLIPS);

    logic [CHANNELS-1:0] lane_busy;
    logic                start_ok;
    logic                all_aligned_q;

    assign align_busy = |lane_busy;
    // Restart is only honoured from a quiet array with a locked PLL.
    assign start_ok   = align_start & pll_locked & ~align_busy;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        lvds_align_lane #(
            .DESER_FACTOR  (DESER_FACTOR),
            .TRAIN_PATTERN (TRAIN_PATTERN),
            .MATCH_COUNT   (MATCH_COUNT),
            .SLIP_SETTLE   (SLIP_SETTLE),
            .MAX_SLIPS     (MAX_SLIPS)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .pll_locked (pll_locked),
            .start      (start_ok),
            .rx_word    (rx_data[i*DESER_FACTOR +: DESER_FACTOR]),
            .bitslip    (rx_bitslip[i]),
            .aligned    (ch_aligned[i]),
            .failed     (ch_fail[i]),
            .busy       (lane_busy[i])
`ifdef LVDS_ALIGN_SLIPCNT_EN
            ,
            .slip_cnt   (slip_count[i*SCW +: SCW])
`else
            // slip counters stay internal to each lane
`endif
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            all_aligned_q <= 1'b0;
        end else if (!pll_locked || start_ok) begin
            all_aligned_q <= 1'b0;
        end else begin
            all_aligned_q <= &ch_aligned;
        end
    end

    assign all_aligned = all_aligned_q;

endmodule
